// File: rtl/spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared definitions for the SPI command sequencer:
//   - state_t    : FSM state encoding of spi_cmd_ctrl
//   - CMD_*      : command byte values decoded at the start of every frame
//   - STATUS_SIG : signature nibble returned in the upper half of a STATUS reply
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,      // waiting for a frame to start
    CMD,       // waiting for the command byte
    ADDR_WR,   // waiting for the start address of a write
    ADDR_RD,   // waiting for the start address of a read
    WR_DATA,   // every received byte is written to the register file
    RD_FETCH,  // read strobe issued, waiting for reg_rdata
    RD_DATA,   // prefetched byte is in tx_data, waiting for the next dummy byte
    DISCARD    // rest of the frame is ignored
  } state_t;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  localparam logic [3:0] STATUS_SIG = 4'hA;

endpackage : spi_ctrl_pkg

// File: rtl/spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl
// Command sequencer between an SPI slave byte layer and a local register file.
// Each frame starts with a command byte (WRITE / READ / STATUS), optionally
// followed by a start address and a stream of data bytes.
//
// Build option:
//   SPI_CMD_CTRL_AUTOINC_EN  defined   -> reg_addr increments after every data
//                                         byte (burst access), wrapping silently
//                            undefined -> reg_addr stays fixed for the frame
//
// Parameters:
//   ADDR_W     register-file address width
//   ERR_CNT_W  width of the saturating bad-command counter
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   frame_active   high while SSEL is asserted (already synchronised)
//   frame_start    one-cycle pulse at SSEL falling edge
//   rx_valid       one-cycle pulse, rx_data holds a complete received byte
//   rx_data        received byte
//   tx_data        byte the SPI layer shifts out at the next byte boundary
//   reg_addr       register-file address
//   reg_wr_en      one-cycle write strobe, with reg_wdata
//   reg_wdata      write data
//   reg_rd_en      one-cycle read strobe
//   reg_rdata      read data, valid exactly one cycle after reg_rd_en
//   err_cnt        saturating count of unknown command bytes
// -----------------------------------------------------------------------------
module spi_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_active,
  input  logic                 frame_start,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic [7:0]           tx_data,
  output logic [ADDR_W-1:0]    reg_addr,
  output logic                 reg_wr_en,
  output logic [7:0]           reg_wdata,
  output logic                 reg_rd_en,
  input  logic [7:0]           reg_rdata,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t                 state, state_n;
  logic [7:0]             tx_n;
  logic [ADDR_W-1:0]      addr_n;
  logic [7:0]             wdata_n;
  logic                   wr_n;
  logic                   rd_n;
  logic [ERR_CNT_W-1:0]   err_n;

  logic [ADDR_W-1:0]      rx_addr;   // rx_data resized to the address width
  logic [3:0]             err_nib;   // err_cnt resized to the status nibble

  // Resize the received byte to an address: truncate or zero-extend.
  if (ADDR_W == 8) begin : g_addr_eq
    assign rx_addr = rx_data;
  end else if (ADDR_W > 8) begin : g_addr_wide
    assign rx_addr = {{(ADDR_W-8){1'b0}}, rx_data};
  end else begin : g_addr_narrow
    assign rx_addr = rx_data[ADDR_W-1:0];
  end

  // The status reply only carries four counter bits.
  if (ERR_CNT_W >= 4) begin : g_err_wide
    assign err_nib = err_cnt[3:0];
  end else begin : g_err_narrow
    assign err_nib = {{(4-ERR_CNT_W){1'b0}}, err_cnt};
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch. Strobes default low, which makes
    // them single-cycle pulses by construction.
    state_n = state;
    tx_n    = tx_data;
    addr_n  = reg_addr;
    wdata_n = reg_wdata;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    err_n   = err_cnt;

`ifdef SPI_CMD_CTRL_AUTOINC_EN
    // A write is presented for one cycle at the current address; the address
    // moves on in the cycle after the strobe.
    if (reg_wr_en) begin
      addr_n = reg_addr + ADDR_W'(1);
    end
`endif

    if (!frame_active) begin
      // Frame ended or aborted: drop back to IDLE and stop issuing strobes.
      state_n = IDLE;
      tx_n    = 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state_n = CMD;
            tx_n    = 8'h00;
          end
        end

        CMD: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_WRITE:  state_n = ADDR_WR;
              CMD_READ:   state_n = ADDR_RD;
              CMD_STATUS: begin
                state_n = DISCARD;
                tx_n    = {STATUS_SIG, err_nib};
              end
              default: begin
                state_n = DISCARD;
                if (err_cnt != '1) begin
                  err_n = err_cnt + ERR_CNT_W'(1);
                end
              end
            endcase
          end
        end

        ADDR_WR: begin
          if (rx_valid) begin
            addr_n  = rx_addr;
            state_n = WR_DATA;
          end
        end

        WR_DATA: begin
          if (rx_valid) begin
            wr_n    = 1'b1;
            wdata_n = rx_data;
          end
        end

        ADDR_RD: begin
          if (rx_valid) begin
            addr_n  = rx_addr;
            rd_n    = 1'b1;
            state_n = RD_FETCH;
          end
        end

        RD_FETCH: begin
          // First cycle here is the strobe cycle; reg_rdata is valid on the
          // second. Any rx_valid seen meanwhile is dropped.
          if (!reg_rd_en) begin
            tx_n    = reg_rdata;
            state_n = RD_DATA;
          end
        end

        RD_DATA: begin
          if (rx_valid) begin
`ifdef SPI_CMD_CTRL_AUTOINC_EN
            addr_n = reg_addr + ADDR_W'(1);
`endif
            rd_n    = 1'b1;
            state_n = RD_FETCH;
          end
        end

        DISCARD: begin
          // Hold tx_data, ignore everything until the frame ends.
        end

        default: state_n = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments only in clocked logic, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_data   <= 8'h00;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      tx_data   <= tx_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_wr_en <= wr_n;
      reg_rd_en <= rd_n;
      err_cnt   <= err_n;
    end
  end

endmodule : spi_cmd_ctrl

// File: tb/tb_spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_ctrl
// Directed bench for spi_cmd_ctrl (ADDR_W=8, ERR_CNT_W=4). A small register
// file model answers reads one cycle after reg_rd_en. Expectations follow the
// SPI_CMD_CTRL_AUTOINC_EN setting of the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_active;
  logic       frame_start;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic [3:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  // register file model, with a bench-side preload port
  logic [7:0] mem [256];
  logic       pl_en;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;

  // write log, filled by step()
  logic [7:0] wlog_a [16];
  logic [7:0] wlog_d [16];
  int         wn;
  int         ovl;

  spi_cmd_ctrl #(.ADDR_W(8), .ERR_CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_active (frame_active),
    .frame_start  (frame_start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_data      (tx_data),
    .reg_addr     (reg_addr),
    .reg_wr_en    (reg_wr_en),
    .reg_wdata    (reg_wdata),
    .reg_rd_en    (reg_rd_en),
    .reg_rdata    (reg_rdata),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (reg_wr_en) mem[reg_addr] <= reg_wdata;
    if (reg_rd_en) reg_rdata <= mem[reg_addr];
  end

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (reg_wr_en && wn < 16) begin
      wlog_a[wn] = reg_addr;
      wlog_d[wn] = reg_wdata;
      wn++;
    end
    if (reg_wr_en && reg_rd_en) ovl++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    repeat (5) step();
  endtask

  task automatic start_frame();
    frame_active = 1'b1;
    frame_start  = 1'b1;
    step();
    frame_start  = 1'b0;
    step();
  endtask

  task automatic end_frame();
    frame_active = 1'b0;
    step();
    step();
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++; if (tx_data   !== 8'h00) begin failures++; $display("FAIL %s tx_data got=%h exp=00", tag, tx_data); end
    checks++; if (reg_addr  !== 8'h00) begin failures++; $display("FAIL %s reg_addr got=%h exp=00", tag, reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin failures++; $display("FAIL %s reg_wdata got=%h exp=00", tag, reg_wdata); end
    checks++; if (reg_wr_en !== 1'b0)  begin failures++; $display("FAIL %s reg_wr_en got=%b exp=0", tag, reg_wr_en); end
    checks++; if (reg_rd_en !== 1'b0)  begin failures++; $display("FAIL %s reg_rd_en got=%b exp=0", tag, reg_rd_en); end
    checks++; if (err_cnt   !== 4'h0)  begin failures++; $display("FAIL %s err_cnt got=%h exp=0", tag, err_cnt); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_active = 1'b0; frame_start = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    wn = 0; ovl = 0;
    #2;
    check_reset_values("reset_initial");
    preload(8'h20, 8'h5C);
    preload(8'h21, 8'h7E);
    preload(8'h30, 8'h9D);
    preload(8'h31, 8'h4B);
    rst_n = 1'b1;
    step();
    check_reset_values("reset_released");
  endtask

  task automatic test_write_burst();
    logic [7:0] exp_a1;
    logic [7:0] exp_end;
`ifdef SPI_CMD_CTRL_AUTOINC_EN
    exp_a1 = 8'h11; exp_end = 8'h12;
`else
    exp_a1 = 8'h10; exp_end = 8'h10;
`endif
    wn = 0;
    start_frame();
    send_byte(8'h02); send_byte(8'h10); send_byte(8'hAA); send_byte(8'hBB);
    checks++; if (reg_addr !== exp_end) begin failures++; $display("FAIL wr_end_addr got=%h exp=%h", reg_addr, exp_end); end
    end_frame();
    checks++; if (wn !== 2) begin failures++; $display("FAIL wr_count got=%0d exp=2", wn); end
    checks++; if (wlog_a[0] !== 8'h10 || wlog_d[0] !== 8'hAA) begin failures++; $display("FAIL wr_0 got=%h/%h exp=10/AA", wlog_a[0], wlog_d[0]); end
    checks++; if (wlog_a[1] !== exp_a1 || wlog_d[1] !== 8'hBB) begin failures++; $display("FAIL wr_1 got=%h/%h exp=%h/BB", wlog_a[1], wlog_d[1], exp_a1); end
  endtask

  task automatic test_read_burst();
    logic [7:0] exp_second;
    logic [7:0] exp_addr2;
`ifdef SPI_CMD_CTRL_AUTOINC_EN
    exp_second = 8'h7E; exp_addr2 = 8'h21;
`else
    exp_second = 8'h5C; exp_addr2 = 8'h20;
`endif
    start_frame();
    send_byte(8'h03);
    // address byte: strobe at +1, tx_data unchanged at +2, loaded at +3
    rx_data = 8'h20; rx_valid = 1'b1;
    step(); rx_valid = 1'b0;
    checks++; if (reg_rd_en !== 1'b1 || reg_addr !== 8'h20) begin failures++; $display("FAIL rd_strobe got=%b/%h exp=1/20", reg_rd_en, reg_addr); end
    step();
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rd_early got=%h exp=00", tx_data); end
    step();
    checks++; if (tx_data !== 8'h5C) begin failures++; $display("FAIL rd_first got=%h exp=5C", tx_data); end
    repeat (3) step();
    // first dummy byte
    rx_data = 8'h00; rx_valid = 1'b1;
    step(); rx_valid = 1'b0;
    checks++; if (reg_rd_en !== 1'b1 || reg_addr !== exp_addr2) begin failures++; $display("FAIL rd_strobe2 got=%b/%h exp=1/%h", reg_rd_en, reg_addr, exp_addr2); end
    step();
    checks++; if (tx_data !== 8'h5C) begin failures++; $display("FAIL rd_hold got=%h exp=5C", tx_data); end
    step();
    checks++; if (tx_data !== exp_second) begin failures++; $display("FAIL rd_second got=%h exp=%h", tx_data, exp_second); end
    repeat (3) step();
    end_frame();
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rd_frame_end got=%h exp=00", tx_data); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a1;
`ifdef SPI_CMD_CTRL_AUTOINC_EN
    exp_a1 = 8'h00;
`else
    exp_a1 = 8'hFF;
`endif
    wn = 0;
    start_frame();
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'h11); send_byte(8'h22);
    end_frame();
    checks++; if (wn !== 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", wn); end
    checks++; if (wlog_a[0] !== 8'hFF || wlog_d[0] !== 8'h11) begin failures++; $display("FAIL wrap_0 got=%h/%h exp=FF/11", wlog_a[0], wlog_d[0]); end
    checks++; if (wlog_a[1] !== exp_a1 || wlog_d[1] !== 8'h22) begin failures++; $display("FAIL wrap_1 got=%h/%h exp=%h/22", wlog_a[1], wlog_d[1], exp_a1); end
  endtask

  task automatic test_bad_commands();
    for (int i = 0; i < 3; i++) begin
      start_frame(); send_byte(8'h99); end_frame();
    end
    checks++; if (err_cnt !== 4'h3) begin failures++; $display("FAIL bad_cnt3 got=%h exp=3", err_cnt); end
    start_frame();
    send_byte(8'h05);
    checks++; if (tx_data !== 8'hA3) begin failures++; $display("FAIL status_3 got=%h exp=A3", tx_data); end
    send_byte(8'h99);  // ignored in DISCARD
    checks++; if (tx_data !== 8'hA3 || err_cnt !== 4'h3) begin failures++; $display("FAIL discard_hold got=%h/%h exp=A3/3", tx_data, err_cnt); end
    end_frame();
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL status_end got=%h exp=00", tx_data); end
    for (int i = 0; i < 20; i++) begin
      start_frame(); send_byte(8'h99); end_frame();
    end
    checks++; if (err_cnt !== 4'hF) begin failures++; $display("FAIL bad_sat got=%h exp=F", err_cnt); end
    start_frame();
    send_byte(8'h05);
    checks++; if (tx_data !== 8'hAF) begin failures++; $display("FAIL status_F got=%h exp=AF", tx_data); end
    end_frame();
  endtask

  task automatic test_abort();
    wn = 0;
    start_frame();
    send_byte(8'h02);
    rx_data = 8'h40; rx_valid = 1'b1;
    step(); rx_valid = 1'b0;
    frame_active = 1'b0;
    step();
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL abort_tx got=%h exp=00", tx_data); end
    send_byte(8'h55);  // frame inactive: must not write
    checks++; if (wn !== 0) begin failures++; $display("FAIL abort_no_write got=%0d exp=0", wn); end
    start_frame();
    send_byte(8'h02); send_byte(8'h41); send_byte(8'h66);
    end_frame();
    checks++; if (wn !== 1 || wlog_a[0] !== 8'h41 || wlog_d[0] !== 8'h66) begin failures++; $display("FAIL abort_next got=%0d %h/%h exp=1 41/66", wn, wlog_a[0], wlog_d[0]); end
  endtask

  task automatic test_reset_mid_read();
    start_frame();
    send_byte(8'h03);
    send_byte(8'h30);
    checks++; if (tx_data !== 8'h9D) begin failures++; $display("FAIL mid_read_tx got=%h exp=9D", tx_data); end
    rx_data = 8'h00; rx_valid = 1'b1;
    step(); rx_valid = 1'b0;
    checks++; if (reg_rd_en !== 1'b1) begin failures++; $display("FAIL mid_read_strobe got=%b exp=1", reg_rd_en); end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("reset_async");
    step();
    check_reset_values("reset_held");
    frame_active = 1'b0;
    rst_n = 1'b1;
    step();
    checks++; if (ovl !== 0) begin failures++; $display("FAIL wr_rd_overlap got=%0d exp=0", ovl); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_bad_commands();
    test_abort();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_spi_cmd_ctrl

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command sequencer between the SPI slave byte layer and a local register file.
- Decodes a per-frame command byte (WRITE / READ / STATUS) and latches a start address.
- Then streams data: writes received bytes into the register file, or prefetches register contents into the SPI transmit byte.
- Frames are delimited by SSEL (active low, synchronised upstream); all logic runs on the fast FPGA clock.

Parameters:
- ADDR_W, 8, register-file address width in bits.
- ERR_CNT_W, 4, width of the saturating bad-command counter.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_active  in  1  high while SSEL is asserted (already synchronised)
- frame_start  in  1  one-cycle pulse on SSEL falling edge
- rx_valid  in  1  one-cycle pulse: a complete byte was received
- rx_data  in  8  received byte; valid when rx_valid=1
- tx_data  out  8  byte the SPI layer loads at the next byte boundary
- reg_addr  out  ADDR_W  register-file address
- reg_wr_en  out  1  one-cycle write strobe
- reg_wdata  out  8  write data
- reg_rd_en  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_rd_en
- err_cnt  out  ERR_CNT_W  saturating count of unknown command bytes

Behaviour:
- Reset values: state IDLE, tx_data=0x00, reg_addr=0, reg_wdata=0, reg_wr_en=0, reg_rd_en=0, err_cnt=0.
- Commands (package constants): CMD_WRITE=0x02, CMD_READ=0x03, CMD_STATUS=0x05.
- FSM states: IDLE, CMD, ADDR_WR, ADDR_RD, WR_DATA, RD_FETCH, RD_DATA, DISCARD.
- Abort rule (highest priority): frame_active=0 in any state -> IDLE next cycle and tx_data<=0x00. Strobes already issued are not retracted; none are issued after the abort cycle.
- IDLE: frame_start=1 -> CMD, tx_data<=0x00.
- CMD, on rx_valid:
  - 0x02 -> ADDR_WR.
  - 0x03 -> ADDR_RD.
  - 0x05 -> DISCARD with tx_data<={4'hA, err_cnt[3:0]}. If ERR_CNT_W<4, zero-extend err_cnt; if >4, use the low 4 bits.
  - Any other byte -> DISCARD, err_cnt+1 saturating at all-ones.
- ADDR_WR, on rx_valid: reg_addr<=rx_data[ADDR_W-1:0] (zero-extend if ADDR_W>8) -> WR_DATA.
- WR_DATA, on rx_valid (cycle t):
  - Cycle t+1: reg_wr_en=1, reg_addr=current, reg_wdata=rx_data.
  - Cycle t+2: reg_addr advances (see Optional Feature).
  - Unlimited burst; stays in WR_DATA.
- ADDR_RD, on rx_valid (cycle t):
  - reg_addr<=rx_data; reg_rd_en=1 at t+1 -> RD_FETCH.
  - RD_FETCH captures reg_rdata into tx_data at t+2 -> RD_DATA.
- RD_DATA, on rx_valid (dummy byte from the master):
  - Advance reg_addr, then issue reg_rd_en -> RD_FETCH.
  - tx_data is updated 3 cycles after rx_valid. SPI half-bit time must exceed 3 clk; this is a system constraint, not checked.
- DISCARD: ignores rx_valid and holds tx_data until the frame ends.
- Address wrap: reg_addr is ADDR_W bits and wraps from all-ones to 0 silently.
- rx_valid while in RD_FETCH: cannot occur under the timing constraint. If it does, the byte is dropped and the FSM still completes the fetch.
- frame_start while frame_active is already high: ignored outside IDLE.
- reg_wr_en and reg_rd_en are never asserted in the same cycle.

Optional Feature:
- Macro: SPI_CMD_CTRL_AUTOINC_EN.
- Defined: reg_addr increments by 1 after every data byte in WR_DATA and RD_DATA (burst access).
- Undefined: reg_addr stays fixed for the whole frame; repeated bytes write or read the same register. The increment logic is absent.

Decomposition:
- Package spi_ctrl_pkg holds:
  - the state enum type;
  - CMD_WRITE, CMD_READ, CMD_STATUS;
  - STATUS_SIG=4'hA.
- No sub-module: FSM, address register and error counter are small enough to live in one module.

Test Plan:
- Write burst: frame 0x02,0x10,0xAA,0xBB -> reg_wr_en pulses with (0x10,0xAA) then (0x11,0xBB) (AUTOINC_EN defined).
- Read burst: regfile[0x20]=0x5C, [0x21]=0x7E; frame 0x03,0x20,dummy,dummy.
  - tx_data=0x5C exactly 3 clk after the address rx_valid.
  - tx_data=0x7E 3 clk after the first dummy byte.
- Bad commands: three frames with command 0x99, then frame 0x05 -> err_cnt=3, tx_data=0xA3; send 20 bad commands -> err_cnt stays 0xF.
- Mid-burst abort: drop frame_active right after the address byte of a write -> FSM IDLE next cycle, no reg_wr_en, tx_data=0x00; the next frame decodes normally.
- Wrap and no-autoinc:
  - Write burst starting at 0xFF -> second write goes to address 0x00.
  - With the macro undefined, both writes go to 0xFF.
- Reset: assert rst_n=0 mid-read -> all outputs at reset values immediately, without waiting for a clk edge.
